// File: rtl/instr_executor.sv
// Batch instruction executor: walks an external instruction register from start_ptr,
// executing one signed ALU instruction at a time with a valid/ready result handshake.
module instr_executor #(
    parameter int ADDR_W    = 5,
    parameter int OPCODE_W  = 4,
    parameter int OPERAND_W = 32
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [ADDR_W-1:0]        start_ptr,
    input  logic [ADDR_W:0]          num_instr,
    output logic [ADDR_W-1:0]        read_pointer,
    input  logic [OPCODE_W-1:0]      opcode,
    input  logic [OPERAND_W-1:0]     operand_a,
    input  logic [OPERAND_W-1:0]     operand_b,
    output logic [2*OPERAND_W-1:0]   result,
    output logic [ADDR_W-1:0]        result_idx,
    output logic                     result_valid,
    input  logic                     result_ready,
    output logic                     div_err,
    output logic                     illegal_op,
    output logic                     busy,
    output logic                     done
);

    localparam int RES_W = 2 * OPERAND_W;

    typedef enum logic [2:0] {IDLE, FETCH, EXEC, HOLD, DONE} state_t;

    state_t                       state;
    logic [ADDR_W:0]              remaining;
    logic [OPCODE_W-1:0]          op_p0;
    logic signed [OPERAND_W-1:0]  a_p0;
    logic signed [OPERAND_W-1:0]  b_p0;
    logic [ADDR_W-1:0]            idx_p0;

    function automatic logic signed [RES_W-1:0] sext(input logic signed [OPERAND_W-1:0] v);
        return {{OPERAND_W{v[OPERAND_W-1]}}, v};
    endfunction

    function automatic logic is_div_op(input logic [OPCODE_W-1:0] op);
        return (op == OPCODE_W'(6)) || (op == OPCODE_W'(7));
    endfunction

    function automatic logic is_illegal_op(input logic [OPCODE_W-1:0] op);
        return op > OPCODE_W'(7);
    endfunction

    // Operands are widened first so ADD/SUB/DIV never overflow (e.g. MIN / -1).
    function automatic logic signed [RES_W-1:0] exec_op(
        input logic [OPCODE_W-1:0]         op,
        input logic signed [OPERAND_W-1:0] a,
        input logic signed [OPERAND_W-1:0] b
    );
        logic signed [RES_W-1:0] ax;
        logic signed [RES_W-1:0] bx;
        logic signed [RES_W-1:0] r;
        ax = sext(a);
        bx = sext(b);
        r  = '0;
        case (op)
            OPCODE_W'(1): r = ax;
            OPCODE_W'(2): r = bx;
            OPCODE_W'(3): r = ax + bx;
            OPCODE_W'(4): r = ax - bx;
            OPCODE_W'(5): r = ax * bx;
            OPCODE_W'(6): if (b != '0) r = ax / bx;
            OPCODE_W'(7): if (b != '0) r = ax % bx;
            default:      r = '0;
        endcase
        return r;
    endfunction

    // FETCH -> EXEC boundary: instruction word captured
    always_ff @(posedge clk) begin
        if (state == FETCH) begin
            op_p0  <= opcode;
            a_p0   <= operand_a;
            b_p0   <= operand_b;
            idx_p0 <= read_pointer;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state        <= IDLE;
            read_pointer <= '0;
            remaining    <= '0;
            result       <= '0;
            result_idx   <= '0;
            result_valid <= 1'b0;
            div_err      <= 1'b0;
            illegal_op   <= 1'b0;
            busy         <= 1'b0;
            done         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (start) begin
                        busy <= 1'b1;
                        if (num_instr != '0) begin
                            read_pointer <= start_ptr;
                            remaining    <= num_instr;
                            state        <= FETCH;
                        end else begin
                            done  <= 1'b1;
                            state <= DONE;
                        end
                    end
                end
                FETCH: state <= EXEC;
                // EXEC -> HOLD boundary: result and flags registered
                EXEC: begin
                    result       <= exec_op(op_p0, a_p0, b_p0);
                    result_idx   <= idx_p0;
                    div_err      <= is_div_op(op_p0) && (b_p0 == '0);
                    illegal_op   <= is_illegal_op(op_p0);
                    result_valid <= 1'b1;
                    state        <= HOLD;
                end
                HOLD: begin
                    if (result_valid && result_ready) begin
                        result_valid <= 1'b0;
                        div_err      <= 1'b0;
                        illegal_op   <= 1'b0;
                        remaining    <= remaining - 1'b1;
                        if (remaining == (ADDR_W+1)'(1)) begin
                            done  <= 1'b1;
                            state <= DONE;
                        end else begin
                            read_pointer <= read_pointer + 1'b1;
                            state        <= FETCH;
                        end
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
